// File: rtl/regs_dbg_port.sv
// Debug initiator for the 32x32 register file.
// Borrows the register-file ports from the core to perform single reads,
// single writes and full 32-register dumps. It stalls the core while it
// owns the ports and returns every result as a beat on a valid/ready stream.
module regs_dbg_port #(
   parameter int unsigned STALL_CYCLES = 1,  // legal 1..7
   parameter int unsigned XLEN         = 32
) (
   input  logic            clk,
   input  logic            reset,        // synchronous, active-low

   // command stream
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [4:0]      cmd_addr,
   input  logic [XLEN-1:0] cmd_wdata,

   // response stream
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [4:0]      rsp_addr,
   output logic [XLEN-1:0] rsp_data,
   output logic            rsp_last,
   output logic            rsp_err,

   // core side
   output logic            core_stall,
   input  logic            core_regwrite,
   input  logic [4:0]      core_rdadr,
   input  logic [XLEN-1:0] core_rd,
   input  logic [4:0]      core_rs1adr,
   input  logic [4:0]      core_rs2adr,

   // register-file side
   output logic            rf_regwrite,
   output logic [4:0]      rf_rdadr,
   output logic [XLEN-1:0] rf_rd,
   output logic [4:0]      rf_rs1adr,
   output logic [4:0]      rf_rs2adr,
   input  logic [XLEN-1:0] rf_rs1
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STALL,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_WRITE,
      S_RESP
   } state_t;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_DUMP  = 2'b10,
      OP_RSVD  = 2'b11
   } op_t;

   // Last count value of the stall window; the counter starts at 0.
   localparam logic [2:0] STALL_LAST = 3'(STALL_CYCLES - 1);
   localparam logic [4:0] LAST_REG   = 5'd31;

   state_t          state_q, state_d;
   op_t             op_q, op_d;
   logic [4:0]      addr_q, addr_d;      // current register (dump index during a dump)
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [4:0]      rsp_addr_q, rsp_addr_d;
   logic [XLEN-1:0] rsp_data_q, rsp_data_d;
   logic            rsp_last_q, rsp_last_d;
   logic            rsp_err_q, rsp_err_d;

   // State and response registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: every state register uses <= so all flops update together from
      // the values they held before the edge, whatever the statement order.
      if (!reset) begin
         state_q    <= S_IDLE;
         op_q       <= OP_READ;
         addr_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         rsp_addr_q <= '0;
         rsp_data_q <= '0;
         rsp_last_q <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         rsp_addr_q <= rsp_addr_d;
         rsp_data_q <= rsp_data_d;
         rsp_last_q <= rsp_last_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   // Next-state logic: command capture, stall window, read/write sequencing, dump stepping.
   always_comb begin
      // NOTE: every signal gets a hold value first, so no path through the
      // case statement leaves one unassigned and no latch is inferred.
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      rsp_addr_d = rsp_addr_q;
      rsp_data_d = rsp_data_q;
      rsp_last_d = rsp_last_q;
      rsp_err_d  = rsp_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               op_d    = op_t'(cmd_op);
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               cnt_d   = '0;
               state_d = S_STALL;
            end
         end

         // Let any core writeback already in flight land before taking the ports.
         S_STALL: begin
            if (cnt_q == STALL_LAST) begin
               cnt_d = '0;
               unique case (op_q)
                  OP_READ:  state_d = S_RD_ISSUE;
                  OP_DUMP: begin
                     addr_d  = '0;
                     state_d = S_RD_ISSUE;
                  end
                  OP_WRITE: state_d = S_WRITE;
                  default: begin
                     rsp_addr_d = addr_q;
                     rsp_data_d = '0;
                     rsp_last_d = 1'b1;
                     rsp_err_d  = 1'b1;
                     state_d    = S_RESP;
                  end
               endcase
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end

         S_RD_ISSUE: state_d = S_RD_WAIT;

         // The register file presents the data one cycle after the address.
         S_RD_WAIT: begin
            rsp_addr_d = addr_q;
            rsp_data_d = rf_rs1;
            rsp_last_d = (op_q != OP_DUMP) || (addr_q == LAST_REG);
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
         end

         S_WRITE: begin
            rsp_addr_d = addr_q;
            rsp_data_d = '0;
            rsp_last_d = 1'b1;
            rsp_err_d  = 1'b0;
            state_d    = S_RESP;
         end

         S_RESP: begin
            if (rsp_ready) begin
               if ((op_q == OP_DUMP) && (addr_q != LAST_REG)) begin
                  addr_d  = addr_q + 5'd1;
                  state_d = S_RD_ISSUE;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Register-file port mux: the core owns the ports in IDLE and STALL, debug otherwise.
   always_comb begin
      if ((state_q == S_IDLE) || (state_q == S_STALL)) begin
         rf_regwrite = core_regwrite;
         rf_rdadr    = core_rdadr;
         rf_rd       = core_rd;
         rf_rs1adr   = core_rs1adr;
         rf_rs2adr   = core_rs2adr;
      end else begin
         rf_regwrite = (state_q == S_WRITE);
         rf_rdadr    = addr_q;
         rf_rd       = wdata_q;
         rf_rs1adr   = addr_q;
         rf_rs2adr   = '0;
      end
   end

   assign cmd_ready  = (state_q == S_IDLE);
   assign core_stall = (state_q != S_IDLE);
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_addr   = rsp_addr_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_last   = rsp_last_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_regs_dbg_port.sv
// Self-checking bench for regs_dbg_port: a behavioural register file with a
// registered rs1 read, a response scoreboard, a table of single commands and
// hand-written sequences for latency, dump back-pressure, port ownership and
// mid-operation reset.
module tb_regs_dbg_port;

   localparam int unsigned STALL_CYCLES = 1;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [4:0]  rsp_addr;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic        rsp_err;
   logic        core_stall;
   logic        core_regwrite;
   logic [4:0]  core_rdadr;
   logic [31:0] core_rd;
   logic [4:0]  core_rs1adr;
   logic [4:0]  core_rs2adr;
   logic        rf_regwrite;
   logic [4:0]  rf_rdadr;
   logic [31:0] rf_rd;
   logic [4:0]  rf_rs1adr;
   logic [4:0]  rf_rs2adr;
   logic [31:0] rf_rs1;

   regs_dbg_port #(.STALL_CYCLES(STALL_CYCLES), .XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
      .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .core_stall(core_stall),
      .core_regwrite(core_regwrite), .core_rdadr(core_rdadr), .core_rd(core_rd),
      .core_rs1adr(core_rs1adr), .core_rs2adr(core_rs2adr),
      .rf_regwrite(rf_regwrite), .rf_rdadr(rf_rdadr), .rf_rd(rf_rd),
      .rf_rs1adr(rf_rs1adr), .rf_rs2adr(rf_rs2adr), .rf_rs1(rf_rs1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural register file: x0 hard-wired to zero, rs1 read registered.
   logic [31:0] rf_mem [32];
   initial for (int i = 0; i < 32; i++) rf_mem[i] = '0;
   always @(posedge clk) begin
      if (rf_regwrite && (rf_rdadr != 5'd0)) rf_mem[rf_rdadr] <= rf_rd;
      rf_rs1 <= (rf_rs1adr == 5'd0) ? 32'd0 : rf_mem[rf_rs1adr];
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Scoreboard of expected response beats.
   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        last;
      logic        err;
   } rsp_t;

   rsp_t sb[$];
   int   wr_pulses = 0;   // debug-owned rf_regwrite cycles
   int   beats     = 0;
   logic held_pending = 1'b0;
   rsp_t held;

   // Response monitor: compares handshaked beats and checks stability under back-pressure.
   always @(negedge clk) begin
      rsp_t e;
      if (core_stall && rf_regwrite) wr_pulses++;
      if (held_pending) begin
         check("hold_valid", {31'd0, rsp_valid}, 32'd1);
         check("hold_addr", {27'd0, rsp_addr}, {27'd0, held.addr});
         check("hold_data", rsp_data, held.data);
      end
      held_pending = rsp_valid && !rsp_ready;
      if (held_pending) held = '{rsp_addr, rsp_data, rsp_last, rsp_err};
      if (rsp_valid && rsp_ready) begin
         beats++;
         if (sb.size() == 0) begin
            check("unexpected_rsp", {27'd0, rsp_addr}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("rsp_addr", {27'd0, rsp_addr}, {27'd0, e.addr});
            check("rsp_data", rsp_data, e.data);
            check("rsp_last", {31'd0, rsp_last}, {31'd0, e.last});
            check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
         end
      end
   end

   // Response-ready driver: fixed level or toggling every cycle.
   logic ready_toggle = 1'b0;
   logic ready_level  = 1'b1;
   initial begin
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ready_toggle) rsp_ready = ~rsp_ready;
         else              rsp_ready = ready_level;
      end
   end

   task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
      bit ok = 0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_wdata = d;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ((sb.size() == 0) && cmd_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         check("done_timeout", 32'd0, 32'd1);
         sb.delete();
      end
   endtask

   task automatic core_write(input logic [4:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      core_regwrite = 1'b1;
      core_rdadr    = a;
      core_rd       = d;
      @(posedge clk);
      #1;
      core_regwrite = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_last;
      logic        exp_err;
      int          exp_wr;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n;
      int p0;
      int b0;

      vecs[0] = '{2'b01, 5'd7,  32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[1] = '{2'b00, 5'd7,  32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, 0};
      vecs[2] = '{2'b01, 5'd0,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[3] = '{2'b00, 5'd0,  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 0};
      vecs[4] = '{2'b11, 5'd3,  32'hAAAA_5555, 32'h0000_0000, 1'b1, 1'b1, 0};
      vecs[5] = '{2'b00, 5'd5,  32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 0};
      vecs[6] = '{2'b01, 5'd31, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[7] = '{2'b00, 5'd31, 32'h0000_0000, 32'hCAFE_F00D, 1'b1, 1'b0, 0};

      reset         = 1'b0;
      cmd_valid     = 1'b0;
      cmd_op        = '0;
      cmd_addr      = '0;
      cmd_wdata     = '0;
      core_regwrite = 1'b0;
      core_rdadr    = '0;
      core_rd       = '0;
      core_rs1adr   = '0;
      core_rs2adr   = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_core_stall", {31'd0, core_stall}, 32'd0);
      check("rst_rsp_addr", {27'd0, rsp_addr}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Core writes x5, then a debug read with latency measurement.
      core_write(5'd5, 32'hDEAD_BEEF);
      sb.push_back('{5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_addr  = 5'd5;
      @(negedge clk);
      check("accept_cycle_ready", {31'd0, cmd_ready}, 32'd1);
      check("accept_cycle_stall", {31'd0, core_stall}, 32'd0);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      check("stall_rise", {31'd0, core_stall}, 32'd1);
      n = 1;
      while (!rsp_valid && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      check("rd_latency", n, 1 + STALL_CYCLES + 2);
      wait_done();
      check("stall_released", {31'd0, core_stall}, 32'd0);

      // Table of single commands.
      for (int i = 0; i < 8; i++) begin
         p0 = wr_pulses;
         sb.push_back('{vecs[i].addr, vecs[i].exp_data, vecs[i].exp_last, vecs[i].exp_err});
         send(vecs[i].op, vecs[i].addr, vecs[i].wdata);
         wait_done();
         check($sformatf("vec%0d_wr_pulses", i), wr_pulses - p0, vecs[i].exp_wr);
         check($sformatf("vec%0d_stall_off", i), {31'd0, core_stall}, 32'd0);
      end

      // Core fills xi = i*3, then a dump under toggling back-pressure.
      for (int i = 0; i < 32; i++) core_write(5'(i), 32'(i * 3));
      for (int i = 0; i < 32; i++) sb.push_back('{5'(i), 32'(i * 3), (i == 31), 1'b0});
      b0 = beats;
      ready_toggle = 1'b1;
      send(2'b10, 5'd17, 32'd0);
      wait_done();
      ready_toggle = 1'b0;
      check("dump_beats", beats - b0, 32);

      // Core write on the accept cycle passes through; later core writes are blocked.
      sb.push_back('{5'd9, 32'hA5A5_A5A5, 1'b1, 1'b0});
      @(posedge clk);
      #1;
      cmd_valid     = 1'b1;
      cmd_op        = 2'b00;
      cmd_addr      = 5'd9;
      core_regwrite = 1'b1;
      core_rdadr    = 5'd9;
      core_rd       = 32'hA5A5_A5A5;
      @(negedge clk);
      check("accept_passthru", {31'd0, rf_regwrite}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid     = 1'b0;
      core_regwrite = 1'b0;
      @(posedge clk);
      #1;
      core_regwrite = 1'b1;
      core_rdadr    = 5'd10;
      core_rd       = 32'h0000_0BAD;
      @(negedge clk);
      check("blocked_rd_issue", {31'd0, rf_regwrite}, 32'd0);
      @(negedge clk);
      check("blocked_rd_wait", {31'd0, rf_regwrite}, 32'd0);
      @(posedge clk);
      #1 core_regwrite = 1'b0;
      wait_done();
      sb.push_back('{5'd10, 32'd30, 1'b1, 1'b0});
      send(2'b00, 5'd10, 32'd0);
      wait_done();

      // Reset during RD_WAIT of a dump aborts it.
      for (int i = 0; i < 32; i++) sb.push_back('{5'(i), 32'(i * 3), (i == 31), 1'b0});
      send(2'b10, 5'd0, 32'd0);
      n = 0;
      while (!(rsp_valid && rsp_ready && (rsp_addr == 5'd3)) && (n < 200)) begin
         @(negedge clk);
         n++;
      end
      check("dump_reach_beat3", {31'd0, (n < 200)}, 32'd1);
      @(posedge clk);          // handshake: RD_ISSUE for x4
      @(posedge clk);          // RD_WAIT
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      sb.delete();
      @(negedge clk);
      check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("abort_core_stall", {31'd0, core_stall}, 32'd0);
      check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid || core_stall) n++;
      end
      check("abort_quiet", n, 0);

      sb.push_back('{5'd5, 32'd15, 1'b1, 1'b0});
      send(2'b00, 5'd5, 32'd0);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
